// File: rtl/sr_mc_sequencer.sv
// Sequencer for one multicycle execution unit (hypotenuse/mul engine).
// It stalls the PC, pulses the unit start and hands ALU ownership to the unit.
// Once the unit's busy drops, it issues exactly one register-file write and
// releases the PC. A wait-cycle bound aborts a hung op and sets a sticky
// error flag.
module sr_mc_sequencer #(
  parameter int CNT_W      = 8,
  parameter int MAX_CYCLES = 200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic [4:0]       issueRd_i,
  input  logic             unitBusy_i,
  input  logic [31:0]      unitResult_i,
  output logic             unitStart_o,
  output logic             aluOwn_o,
  output logic             pcWe_o,
  output logic             regWrite_o,
  output logic [4:0]       wdAddr_o,
  output logic [31:0]      wdData_o,
  output logic             timeoutErr_o,
  output logic [CNT_W-1:0] lastLatency_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic              tout_q, tout_d;

  logic [CNT_W-1:0]  cnt_inc_s;
  logic [CNT_W-1:0]  max_s;

  // The counter never wraps because MAX_CYCLES is below 2**CNT_W.
  assign cnt_inc_s = cnt_q + CNT_W'(1);
  assign max_s     = CNT_W'(MAX_CYCLES);

  // Next-state logic: accept one op from IDLE, then wait for busy to drop or time out.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        if (issue_i) begin
          rd_d    = issueRd_i;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc_s;
        // A busy drop wins over the timeout when both land in the same cycle.
        if (!unitBusy_i) begin
          res_d   = unitResult_i;
          lat_d   = cnt_inc_s;
          state_d = S_COMMIT;
        end else if (cnt_inc_s == max_s) begin
          tout_d  = 1'b1;
          state_d = S_ABORT;
        end else begin
          state_d = S_WAIT;
        end
      end
      // The instruction being committed still decodes as an issue, so issue is ignored here.
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state; every strobe is forced low while in reset.
  always_comb begin
    unitStart_o = 1'b0;
    aluOwn_o    = 1'b0;
    pcWe_o      = 1'b0;
    regWrite_o  = 1'b0;
    wdAddr_o    = 5'd0;
    wdData_o    = 32'd0;
    if (rst_i) begin
      pcWe_o = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pcWe_o = !issue_i;
        end
        S_START: begin
          unitStart_o = 1'b1;
          aluOwn_o    = 1'b1;
        end
        S_WAIT: begin
          aluOwn_o = 1'b1;
        end
        S_COMMIT: begin
          // A destination of x0 runs the full sequence but never writes.
          regWrite_o = (rd_q != 5'd0);
          wdAddr_o   = rd_q;
          wdData_o   = res_q;
          pcWe_o     = 1'b1;
        end
        S_ABORT: begin
          // The PC skips the instruction whose unit hung.
          pcWe_o = 1'b1;
        end
        default: begin
          pcWe_o = 1'b0;
        end
      endcase
    end
  end

  assign timeoutErr_o  = tout_q;
  assign lastLatency_o = lat_q;

  // State register with synchronous reset that discards any op in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rd_q    <= 5'd0;
      res_q   <= 32'd0;
      cnt_q   <= '0;
      lat_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      tout_q  <= tout_d;
    end
  end

endmodule

// File: tb/tb_sr_mc_sequencer.sv
// Scoreboard bench for sr_mc_sequencer: the driver pushes the expected outcome
// of each op, a unit model answers the start pulse, and a monitor checks each
// completed stall.
module tb_sr_mc_sequencer;
  localparam int CNT_W = 8;
  localparam int MAX   = 200;

  logic             clk;
  logic             rst;
  logic             issue;
  logic [4:0]       issueRd;
  logic             unitBusy;
  logic [31:0]      unitResult;
  logic             unitStart_o, aluOwn_o, pcWe_o, regWrite_o, timeoutErr_o;
  logic [4:0]       wdAddr_o;
  logic [31:0]      wdData_o;
  logic [CNT_W-1:0] lastLatency_o;

  sr_mc_sequencer #(.CNT_W(CNT_W), .MAX_CYCLES(MAX)) dut (
    .clk_i(clk), .rst_i(rst), .issue_i(issue), .issueRd_i(issueRd),
    .unitBusy_i(unitBusy), .unitResult_i(unitResult),
    .unitStart_o(unitStart_o), .aluOwn_o(aluOwn_o), .pcWe_o(pcWe_o),
    .regWrite_o(regWrite_o), .wdAddr_o(wdAddr_o), .wdData_o(wdData_o),
    .timeoutErr_o(timeoutErr_o), .lastLatency_o(lastLatency_o)
  );

  typedef struct {
    bit          commit;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
    bit          tout;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: the latency of the last committed op and the sticky error.
  int   m_lat;
  bit   m_tout;

  // Unit behaviour for the current op: busy for u_busy_len cycles after start.
  int          u_busy_len;
  logic [31:0] u_result;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unit model: responds to the start pulse; drives junk data while busy.
  initial begin
    bit st;
    bit act;
    int k;
    unitBusy   = 1'b0;
    unitResult = 32'd0;
    act = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      st = unitStart_o;
      @(posedge clk);
      #1;
      if (st) begin
        act = 1'b1;
        k = 1;
      end else if (act) begin
        k++;
      end
      if (act && k <= u_busy_len) begin
        unitBusy   = 1'b1;
        unitResult = $urandom;
      end else begin
        unitBusy   = 1'b0;
        unitResult = act ? u_result : $urandom;
      end
    end
  end

  // Monitor: measures each stall and compares its outcome against the scoreboard.
  initial begin
    bit   in_stall = 1'b0;
    bit   rst_prev = 1'b0;
    int   stall = 0;
    int   starts = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        in_stall = 1'b0;
        chk("rst_unitStart", unitStart_o, 0);
        chk("rst_aluOwn", aluOwn_o, 0);
        chk("rst_pcWe", pcWe_o, 0);
        chk("rst_regWrite", regWrite_o, 0);
        chk("rst_wdAddr", wdAddr_o, 0);
        chk("rst_wdData", wdData_o, 0);
        if (rst_prev) begin
          chk("rst_lastLatency", lastLatency_o, 0);
          chk("rst_timeoutErr", timeoutErr_o, 0);
        end
      end else if (!in_stall) begin
        if (regWrite_o) chk("stray_regWrite", regWrite_o, 0);
        if (!pcWe_o) begin
          in_stall = 1'b1;
          stall = 1;
          starts = int'(unitStart_o);
        end
      end else if (!pcWe_o) begin
        stall++;
        starts += int'(unitStart_o);
        if (regWrite_o) chk("stall_regWrite", regWrite_o, 0);
      end else begin
        in_stall = 1'b0;
        if (sbq.size() == 0) begin
          chk("unexpected_op_end", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("start_pulses", starts, 1);
          chk("timeoutErr", timeoutErr_o, e.tout);
          chk("lastLatency", lastLatency_o, e.lat);
          if (e.commit) begin
            chk("stall_len", stall, e.lat + 2);
            chk("regWrite", regWrite_o, (e.rd != 5'd0));
            if (e.rd != 5'd0) begin
              chk("wdAddr", wdAddr_o, e.rd);
              chk("wdData", wdData_o, e.data);
            end
          end else begin
            chk("abort_stall_len", stall, MAX + 2);
            chk("abort_regWrite", regWrite_o, 0);
          end
        end
      end
      rst_prev = rst;
    end
  end

  // One op: present the instruction, predict its outcome, hold it until the PC advances.
  task automatic run_op(input logic [4:0] rd, input logic [31:0] data, input int b, input bit wait_edge);
    exp_t e;
    bit   done = 1'b0;
    if (wait_edge) begin
      @(posedge clk);
      #1;
    end
    issue      = 1'b1;
    issueRd    = rd;
    u_busy_len = b;
    u_result   = data;
    if (b + 1 <= MAX) begin
      e.commit = 1'b1;
      m_lat    = b + 1;
    end else begin
      e.commit = 1'b0;
      m_tout   = 1'b1;
    end
    e.rd   = rd;
    e.data = data;
    e.lat  = m_lat;
    e.tout = m_tout;
    sbq.push_back(e);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pcWe_o) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("op_completes", 0, 1);
    @(posedge clk);
    #1;
    issue   = 1'b0;
    issueRd = 5'($urandom);
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++)
      run_op(5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 12), 1'b1);
  endtask

  // Stimulus: directed corner cases interleaved with randomized ops.
  initial begin
    rst = 1'b1;
    issue = 1'b0;
    issueRd = 5'd0;
    u_busy_len = 0;
    u_result = 32'd0;
    m_lat = 0;
    m_tout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(5'd5, 32'h0000_0005, 3, 1'b1);                    // basic op, latency 4
    run_op(5'($urandom_range(1, 31)), $urandom, 0, 1'b1);    // zero-latency unit
    run_op(5'd9, $urandom, MAX - 1, 1'b1);                   // busy drops on the last WAIT cycle
    run_op(5'd0, 32'hDEAD_BEEF, 2, 1'b1);                    // x0 destination
    rand_ops(8);
    run_op(5'd7, $urandom, 255, 1'b1);                       // timeout
    run_op(5'd12, $urandom, 1, 1'b1);                        // good op with sticky flag set
    rand_ops(3);

    // Reset in the middle of a WAIT phase, then issue immediately on release.
    @(posedge clk);
    #1;
    issue      = 1'b1;
    issueRd    = 5'd3;
    u_busy_len = 10;
    u_result   = $urandom;
    repeat (4) @(posedge clk);
    #1;
    rst    = 1'b1;
    m_lat  = 0;
    m_tout = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(5'd17, $urandom, 2, 1'b0);
    rand_ops(3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
